fft_spectrum_buffer: RTL and testbench

Downstream of the FFT IP core, the stage after `fft_input_handler` → FFT. Accepts the FFT's complex AXI-Stream output and computes an approximate magnitude per bin. Stores the first FFT_SIZE/2 bins in a double-buffered spectrum RAM. The display/readout logic reads one stable, complete frame while the next frame is written.

---
 rtl/fft_spectrum_buffer.sv | 145 ++++++++++++++
 tb/tb_fft_spectrum_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_spectrum_buffer.sv
// Approximate-magnitude spectrum buffer for FFT AXI-Stream output.
// Lower-half bins go to a double-buffered RAM; readers see the last committed frame.
module fft_spectrum_buffer #(
  parameter int FFT_WIDTH  = 16,
  parameter int FFT_SIZE   = 1024,
  parameter int MAG_WIDTH  = FFT_WIDTH,
  parameter int ADDR_WIDTH = $clog2(FFT_SIZE/2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*FFT_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [MAG_WIDTH-1:0]   rd_data,
  output logic                   spectrum_valid,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
  output logic                   frame_error
);

  localparam int CTR_W = $clog2(FFT_SIZE);
  localparam int HALF  = FFT_SIZE / 2;
  localparam logic [CTR_W-1:0] LAST_BIN = CTR_W'(FFT_SIZE - 1);

  logic [CTR_W-1:0] bin_ctr;
  logic             wr_bank;
  logic             rd_bank;
  logic             accept;
  logic             ctr_at_last;

  logic [FFT_WIDTH-1:0] re_in;
  logic [FFT_WIDTH-1:0] im_in;
  logic [FFT_WIDTH:0]   re_ext;
  logic [FFT_WIDTH:0]   im_ext;
  logic [FFT_WIDTH:0]   abs_re;
  logic [FFT_WIDTH:0]   abs_im;

  // Stage 1: absolute values plus write/commit tags
  logic                  v1;
  logic                  we1;
  logic                  commit1;
  logic                  bank1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [FFT_WIDTH:0]    abs_re1;
  logic [FFT_WIDTH:0]    abs_im1;

  // Stage 2: magnitude plus write/commit tags
  logic                  v2;
  logic                  we2;
  logic                  commit2;
  logic                  bank2;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [MAG_WIDTH-1:0]  mag2;

  logic [FFT_WIDTH:0] mag_max;
  logic [FFT_WIDTH:0] mag_min;
  logic [FFT_WIDTH:0] mag_full;

  logic [MAG_WIDTH-1:0] mem0 [HALF];
  logic [MAG_WIDTH-1:0] mem1 [HALF];

  assign accept      = s_axis_tvalid && s_axis_tready;
  assign ctr_at_last = (bin_ctr == LAST_BIN);
  assign re_in       = s_axis_tdata[FFT_WIDTH-1:0];
  assign im_in       = s_axis_tdata[2*FFT_WIDTH-1:FFT_WIDTH];

  always_comb begin
    re_ext = {re_in[FFT_WIDTH-1], re_in};
    im_ext = {im_in[FFT_WIDTH-1], im_in};
    abs_re = re_in[FFT_WIDTH-1] ? (~re_ext + (FFT_WIDTH+1)'(1)) : re_ext;
    abs_im = im_in[FFT_WIDTH-1] ? (~im_ext + (FFT_WIDTH+1)'(1)) : im_ext;
  end

  always_comb begin
    mag_max = abs_re1;
    mag_min = abs_im1;
    if (abs_im1 > abs_re1) begin
      mag_max = abs_im1;
      mag_min = abs_re1;
    end
    mag_full = mag_max + (mag_min >> 1);
  end

  always_ff @(posedge clk) begin
    abs_re1 <= abs_re;
    abs_im1 <= abs_im;
    we1     <= (bin_ctr < CTR_W'(HALF));
    commit1 <= s_axis_tlast && ctr_at_last;
    bank1   <= wr_bank;
    addr1   <= bin_ctr[ADDR_WIDTH-1:0];
    mag2    <= MAG_WIDTH'(mag_full);
    we2     <= we1;
    commit2 <= commit1;
    bank2   <= bank1;
    addr2   <= addr1;
  end

  // wr_bank flips at accept of the committing beat rather than at its retire,
  // so a back-to-back next frame already captures the fresh bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axis_tready  <= 1'b0;
      bin_ctr        <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b1;
      v1             <= 1'b0;
      v2             <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      spectrum_valid <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      v1            <= accept;
      v2            <= v1;
      frame_done    <= 1'b0;
      if (accept) begin
        bin_ctr <= s_axis_tlast ? '0 : bin_ctr + CTR_W'(1);
        if (s_axis_tlast != ctr_at_last) frame_error <= 1'b1;
        if (s_axis_tlast && ctr_at_last) wr_bank <= ~wr_bank;
      end
      if (v2 && commit2) begin
        rd_bank        <= bank2;
        frame_done     <= 1'b1;
        frame_count    <= frame_count + 16'd1;
        spectrum_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && v2 && we2) begin
      if (bank2) mem1[addr2] <= mag2;
      else       mem0[addr2] <= mag2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Directed bench for fft_spectrum_buffer: commit timing, magnitudes,
// double buffering, framing errors and mid-frame reset.
module tb_fft_spectrum_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data;
  logic        spectrum_valid;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        frame_error;

  int checks = 0;
  int errors = 0;

  fft_spectrum_buffer #(.FFT_WIDTH(16), .FFT_SIZE(1024), .MAG_WIDTH(16), .ADDR_WIDTH(9)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .spectrum_valid(spectrum_valid), .frame_done(frame_done),
    .frame_count(frame_count), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: every beat (re_c, im_c); mode 1: extremes in bins 0..2, (8,6) elsewhere
  // in the lower half, distinct junk in the upper half.
  task automatic send_frame(input int mode, input int nbeats, input int last_at, input bit gaps,
                            input logic [15:0] re_c, input logic [15:0] im_c);
    logic [15:0] re;
    logic [15:0] im;
    for (int k = 0; k < nbeats; k++) begin
      re = re_c;
      im = im_c;
      if (mode == 1) begin
        if (k == 0)        begin re = 16'h8000; im = 16'h8000; end
        else if (k == 1)   begin re = 16'h7FFF; im = 16'h0000; end
        else if (k == 2)   begin re = 16'h0000; im = 16'h0000; end
        else if (k < 512)  begin re = 16'd8;    im = 16'd6;    end
        else               begin re = 16'(k);   im = 16'(-k);  end
      end
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      @(negedge clk);
      s_axis_tdata  = {im, re};
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (k == last_at);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Called at the negedge right after the final accept edge E0.
  task automatic finish_frame(input string tag, input bit commit, input int exp_count);
    check({tag, "_done_e0"}, frame_done, 0);
    @(negedge clk);
    check({tag, "_done_e1"}, frame_done, 0);
    @(negedge clk);
    check({tag, "_done_e2"}, frame_done, commit);
    check({tag, "_count"}, frame_count, exp_count);
    @(negedge clk);
    check({tag, "_done_after"}, frame_done, 0);
  endtask

  task automatic read_bin(input string tag, input int addr, input int exp);
    @(negedge clk);
    rd_addr = 9'(addr);
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_valid", spectrum_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", frame_count, 0);
    check("rst_error", frame_error, 0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_up", s_axis_tready, 1);

    // Constant frame re=3 im=-4 -> 5
    send_frame(0, 1024, 1023, 1'b0, 16'd3, 16'hFFFC);
    check("const_valid_pre", spectrum_valid, 0);
    finish_frame("const", 1'b1, 1);
    check("const_valid", spectrum_valid, 1);
    check("const_error", frame_error, 0);
    read_bin("const_bin0", 0, 5);
    read_bin("const_bin255", 255, 5);
    read_bin("const_bin511", 511, 5);

    // Extremes
    send_frame(1, 1024, 1023, 1'b0, 16'd0, 16'd0);
    finish_frame("ext", 1'b1, 2);
    read_bin("ext_bin0", 0, 49152);
    read_bin("ext_bin1", 1, 32767);
    read_bin("ext_bin2", 2, 0);
    read_bin("ext_bin200", 200, 11);
    read_bin("ext_bin511", 511, 11);

    // Frame A: mag 10
    send_frame(0, 1024, 1023, 1'b0, 16'd10, 16'd0);
    finish_frame("frameA", 1'b1, 3);
    read_bin("frameA_bin7", 7, 10);

    // Frame B: mag 20, polling bin 7; commit edge E2 is accept index 1025
    @(negedge clk);
    rd_addr = 9'd7;
    for (int k = 0; k <= 1030; k++) begin
      @(negedge clk);
      if (k >= 1) check("dbuf_bin7", rd_data, ((k - 1) <= 1025) ? 10 : 20);
      if (k < 1024) begin
        s_axis_tdata  = {16'd0, 16'd20};
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = (k == 1023);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
    end
    check("frameB_count", frame_count, 4);
    check("frameB_error", frame_error, 0);

    // Early tlast on beat 100
    send_frame(0, 101, 100, 1'b0, 16'd30, 16'd0);
    check("early_error", frame_error, 1);
    finish_frame("early", 1'b0, 4);
    read_bin("early_bin7", 7, 20);
    read_bin("early_bin50", 50, 20);
    send_frame(0, 1024, 1023, 1'b0, 16'd40, 16'd0);
    finish_frame("after_early", 1'b1, 5);
    check("after_early_error", frame_error, 1);
    read_bin("after_early_bin50", 50, 40);
    read_bin("after_early_bin511", 511, 40);

    // Random gaps with correct tlast
    send_frame(0, 1024, 1023, 1'b1, 16'd0, 16'd50);
    finish_frame("gaps", 1'b1, 6);
    read_bin("gaps_bin3", 3, 50);
    read_bin("gaps_bin400", 400, 50);

    // Missing tlast: no commit, counter wraps so the next frame lines up
    send_frame(0, 1024, -1, 1'b0, 16'd60, 16'd0);
    finish_frame("notlast", 1'b0, 6);
    read_bin("notlast_bin7", 7, 50);
    send_frame(0, 1024, 1023, 1'b0, 16'd70, 16'd0);
    finish_frame("wrap", 1'b1, 7);
    read_bin("wrap_bin0", 0, 70);
    read_bin("wrap_bin511", 511, 70);

    // Reset at beat 300
    send_frame(0, 300, -1, 1'b0, 16'd80, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_tready", s_axis_tready, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_valid", spectrum_valid, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_count", frame_count, 0);
    check("mid_rst_error", frame_error, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tready_up", s_axis_tready, 1);
    send_frame(0, 1024, 1023, 1'b0, 16'd90, 16'd0);
    finish_frame("post_rst", 1'b1, 1);
    check("post_rst_valid", spectrum_valid, 1);
    check("post_rst_error", frame_error, 0);
    read_bin("post_rst_bin0", 0, 90);
    read_bin("post_rst_bin299", 299, 90);
    read_bin("post_rst_bin511", 511, 90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
